// File: rtl/maxpool2x2_relu_stream.sv
// Streaming 2x2 / stride-2 max pool over a raster IEEE-754 single-precision pixel stream.
// Define MAXPOOL_RELU_EN to add ReLU with a magnitude compare; otherwise no activation and full IEEE ordering.
module maxpool2x2_relu_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

    // Returns b only when it orders strictly above a, so ties keep a bit-for-bit.
    function automatic logic [DATA_WIDTH-1:0] pickMax(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
`ifdef MAXPOOL_RELU_EN
        return (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
`else
        logic bothZero;
        logic bWins;
        bothZero = (a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0);
        case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
            2'b00:   bWins = b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
            2'b01:   bWins = 1'b0;
            2'b10:   bWins = !bothZero;
            default: bWins = b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0];
        endcase
        return bWins ? b : a;
`endif
    endfunction

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  valid_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] linebuf_q [HALF];

    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] pairMax;
    logic [DATA_WIDTH-1:0] windowMax;
    logic [HW-1:0]         lbIdx;
    logic                  lastCol;
    logic                  lastRow;

    always_comb begin
`ifdef MAXPOOL_RELU_EN
        x = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
        x = data_in;
`endif
    end

    assign lbIdx     = HW'(col_q >> 1);
    assign lastCol   = (col_q == CW'(WIDTH - 1));
    assign lastRow   = (row_q == RW'(HEIGHT - 1));
    assign pairMax   = pickMax(hold_q, x);
    assign windowMax = pickMax(linebuf_q[lbIdx], pairMax);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (lastCol) begin
                col_d = '0;
                row_d = lastRow ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (valid_in) begin
                if (!col_q[0]) begin
                    hold_q <= x;
                end else if (row_q[0]) begin
                    valid_q <= 1'b1;
                    data_q  <= windowMax;
                    done_q  <= lastRow && lastCol;
                end
            end
        end
    end

    // Even rows always fill an entry before the odd row reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        if (valid_in && col_q[0] && !row_q[0]) begin
            linebuf_q[lbIdx] <= pairMax;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign frame_done = done_q;

endmodule
